// File: rtl/bcd_time_counter.sv
// 24 h packed-BCD time-of-day counter with 1 Hz prescaler and front-panel adjust buttons.
// Optional alarm compare is built when ALARM_EN is defined.
module bcd_time_counter #(
    parameter int unsigned CLK_DIV = 50_000_000,
    parameter int unsigned DIV_W   = 26
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       hold,
    input  logic       adj_sec,
    input  logic       adj_min,
    input  logic       adj_hour,
`ifdef ALARM_EN
    input  logic [7:0] alarm_hour,
    input  logic [7:0] alarm_min,
    output logic       alarm,
`endif
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic       tick
);

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] presc;
    logic             sec_prev, min_prev, hour_prev;
    logic             sec_edge, min_edge, hour_edge;
    logic             tick_fire, carry_min, carry_hour;
    logic             min_step, hour_step;
    logic [7:0]       sec_next, min_next, hour_next;

    // Increment a packed-BCD pair, returning to 00 after 'last'.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last) return '0;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        sec_edge   = adj_sec  & ~sec_prev;
        min_edge   = adj_min  & ~min_prev;
        hour_edge  = adj_hour & ~hour_prev;

        // A seconds clear owns the prescaler that cycle, so it swallows any tick.
        tick_fire  = ~hold & ~sec_edge & (presc == PRESC_LAST);
        carry_min  = tick_fire & (second == 8'h59);
        carry_hour = carry_min & (minute == 8'h59);

        // Carry and button arriving together advance the field only once.
        min_step   = carry_min  | min_edge;
        hour_step  = carry_hour | hour_edge;

        sec_next = second;
        if (sec_edge)
            sec_next = '0;
        else if (tick_fire)
            sec_next = bcd_inc(second, 8'h59);

        min_next  = min_step  ? bcd_inc(minute, 8'h59) : minute;
        hour_next = hour_step ? bcd_inc(hour,   8'h23) : hour;
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            presc     <= '0;
            sec_prev  <= 1'b0;
            min_prev  <= 1'b0;
            hour_prev <= 1'b0;
            tick      <= 1'b0;
            second    <= '0;
            minute    <= '0;
            hour      <= '0;
        end else begin
            sec_prev  <= adj_sec;
            min_prev  <= adj_min;
            hour_prev <= adj_hour;
            tick      <= tick_fire;
            if (sec_edge || tick_fire)
                presc <= '0;
            else if (!hold)
                presc <= presc + DIV_W'(1);
            second <= sec_next;
            minute <= min_next;
            hour   <= hour_next;
        end
    end

`ifdef ALARM_EN
    logic alarm_set, alarm_clr;

    always_comb begin
        // Only a tick carry into alarm_hour:alarm_min:00 arms it; any button press disarms.
        alarm_set = carry_min & ~min_edge & ~hour_edge
                  & (min_next == alarm_min) & (hour_next == alarm_hour);
        alarm_clr = min_step | sec_edge | min_edge | hour_edge;
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR)
            alarm <= 1'b0;
        else if (alarm_set)
            alarm <= 1'b1;
        else if (alarm_clr)
            alarm <= 1'b0;
    end
`endif

endmodule
